// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: Moore FSM sequencing FETCH/DECODE and
// the per-class execute states, plus the condition-flag register used by
// conditional execution.
// Optional feature macro: MULTICYCLE_CONTROLLER_BL_EN (branch-with-link
// writes PC+4 to R14 during BRANCH). Undefined: BL behaves as plain B.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Z,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        WDSrc,
    output logic        ALUSrcA,
    output logic        shifterSrc,
    output logic        AdrSrc,
    output logic        shSrc,
    output logic [3:0]  ALUControl,
    output logic [2:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  shamtSrc,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } stateT;

    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    stateT curState, nextState;
    logic  zFlag;
    logic  condOk;

    // Instruction fields (L and S share bit 20; meaning depends on op)
    logic [1:0] op;
    logic       iBit, sBit, uBit, link;
    logic [3:0] cmd, cond, rd;
    assign op   = Instr[27:26];
    assign iBit = Instr[25];
    assign cmd  = Instr[24:21];
    assign sBit = Instr[20];
    assign uBit = Instr[23];
    assign link = Instr[24];
    assign cond = Instr[31:28];
    assign rd   = Instr[15:12];

    // Register-number and offset fields are datapath-only
    logic unusedBits;
    assign unusedBits = ^{Instr[19:16], Instr[11:0]};

    // Raw write enables before the reset gate
    logic regWriteD, memWriteD, pcWriteD, irWriteD;

    // Condition evaluation against the stored flag
    always_comb begin
        case (cond)
            4'b0000: condOk = zFlag;
            4'b0001: condOk = ~zFlag;
            4'b1110: condOk = 1'b1;
            default: condOk = 1'b0;
        endcase
    end

    // Next-state selection
    always_comb begin
        nextState = FETCH;
        case (curState)
            FETCH:  nextState = DECODE;
            DECODE: begin
                if (!condOk)           nextState = FETCH;
                else if (op == 2'b00)  nextState = iBit ? EXECI : EXECR;
                else if (op == 2'b01)  nextState = MEMADR;
                else if (op == 2'b10)  nextState = BRANCH;
                else                   nextState = FETCH;
            end
            MEMADR:  nextState = sBit ? MEMREAD : MEMWRITE;
            MEMREAD: nextState = MEMWB;
            EXECR, EXECI: nextState = (cmd == CMD_CMP) ? FETCH : ALUWB;
            default: nextState = FETCH;
        endcase
    end

    // State register and zero flag; reset abandons any in-flight instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curState <= FETCH;
            zFlag    <= 1'b0;
        end else begin
            curState <= nextState;
            if ((curState == EXECR || curState == EXECI) && (sBit || cmd == CMD_CMP))
                zFlag <= Z;
        end
    end

    // Moore output decode. Kept combinational from the state register
    // because several controls follow the live IR, and the FETCH enables
    // must be active in the very first cycle after reset release.
    always_comb begin
        regWriteD  = 1'b0;
        memWriteD  = 1'b0;
        pcWriteD   = 1'b0;
        irWriteD   = 1'b0;
        WDSrc      = 1'b0;
        ALUSrcA    = 1'b0;
        shifterSrc = 1'b0;
        AdrSrc     = 1'b0;
        shSrc      = 1'b0;
        ALUControl = 4'b0000;
        RegSrc     = 3'b000;
        ImmSrc     = 2'b00;
        ALUSrcB    = 2'b00;
        shamtSrc   = 2'b00;
        ResultSrc  = 2'b00;
        case (curState)
            FETCH: begin
                irWriteD   = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b10;
                pcWriteD   = 1'b1;
            end
            DECODE: begin
                // PC+8 on Result so R15 reads see the architectural value
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b10;
                RegSrc[1]  = (op == 2'b01) && !sBit;
                RegSrc[0]  = (op == 2'b10);
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b01;
                ALUControl = uBit ? ALU_ADD : ALU_SUB;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regWriteD = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                memWriteD = 1'b1;
                RegSrc[1] = 1'b1;
            end
            EXECR: ALUControl = cmd;
            EXECI: begin
                shifterSrc = 1'b1;
                shamtSrc   = 2'b01;
                shSrc      = 1'b1;
                ALUControl = cmd;
            end
            ALUWB: begin
                regWriteD = 1'b1;
                pcWriteD  = (rd == 4'b1111);
            end
            BRANCH: begin
                RegSrc[0]  = 1'b1;
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b10;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b10;
                pcWriteD   = 1'b1;
`ifdef MULTICYCLE_CONTROLLER_BL_EN
                if (link) begin
                    regWriteD = 1'b1;
                    WDSrc     = 1'b1;
                    RegSrc[2] = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    // Write enables are held off while reset is asserted
    assign RegWrite = regWriteD & reset;
    assign MemWrite = memWriteD & reset;
    assign PCWrite  = pcWriteD  & reset;
    assign IRWrite  = irWriteD  & reset;
    assign state    = curState;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction sequences plus
// random instructions, checked against an instruction-class model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        Z;
    logic        RegWrite, MemWrite, PCWrite, IRWrite, WDSrc, ALUSrcA;
    logic        shifterSrc, AdrSrc, shSrc;
    logic [3:0]  ALUControl;
    logic [2:0]  RegSrc;
    logic [1:0]  ImmSrc, ALUSrcB, shamtSrc, ResultSrc;
    logic [3:0]  state;

    int compared   = 0;
    int mismatched = 0;
    bit zf         = 1'b0;   // model of the condition flag

`ifdef MULTICYCLE_CONTROLLER_BL_EN
    localparam bit BL_EN = 1'b1;
`else
    localparam bit BL_EN = 1'b0;
`endif

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .Z(Z),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .PCWrite(PCWrite),
        .IRWrite(IRWrite), .WDSrc(WDSrc), .ALUSrcA(ALUSrcA),
        .shifterSrc(shifterSrc), .AdrSrc(AdrSrc), .shSrc(shSrc),
        .ALUControl(ALUControl), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
        .ALUSrcB(ALUSrcB), .shamtSrc(shamtSrc), .ResultSrc(ResultSrc),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Auxiliary mux selects expected in a given state
    // {ALUSrcA, AdrSrc, WDSrc, shifterSrc, shSrc, ALUSrcB, ImmSrc, shamtSrc, ResultSrc}
    function automatic logic [12:0] expMux(input int s, input bit lnk);
        case (s)
            0, 1: return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10};
            2:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00};
            3, 5: return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
            4:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01};
            7:    return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00};
            9:    return {1'b0, 1'b0, lnk,  1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b10};
            default: return 13'd0;
        endcase
    endfunction

    // Runs one instruction from FETCH to its last cycle, checking every cycle.
    // Entered at a falling edge with the controller in FETCH.
    task automatic runInstr(input logic [31:0] ins, input logic z);
        int  seq[$];
        int  n;
        bit  condOk, isCmp, lnk;
        bit  regWLast, memWLast, pcWLast;
        logic [1:0] op;
        logic [3:0] cmd, cond;
        op   = ins[27:26];
        cmd  = ins[24:21];
        cond = ins[31:28];
        condOk = (cond == 4'd0) ? zf : (cond == 4'd1) ? !zf : (cond == 4'd14);
        isCmp  = (cmd == 4'b1010);
        lnk    = BL_EN && ins[24] && op == 2'b10;
        regWLast = 0; memWLast = 0; pcWLast = 0;
        seq = '{0, 1};
        if (condOk && op == 2'b00) begin
            seq.push_back(ins[25] ? 7 : 6);
            if (!isCmp) begin
                seq.push_back(8);
                regWLast = 1;
                pcWLast  = (ins[15:12] == 4'hF);
            end
        end else if (condOk && op == 2'b01) begin
            seq.push_back(2);
            if (ins[20]) begin seq.push_back(3); seq.push_back(4); regWLast = 1; end
            else begin seq.push_back(5); memWLast = 1; end
        end else if (condOk && op == 2'b10) begin
            seq.push_back(9);
            pcWLast  = 1;
            regWLast = lnk;
        end
        n = seq.size();
        Instr = ins;
        Z     = z;
        #1;
        for (int k = 0; k < n; k++) begin
            bit last;
            logic [3:0] aluExp;
            logic [2:0] rsExp;
            last = (k == n - 1) && (k >= 2);
            chk("state", state, seq[k]);
            chk("IRWrite", IRWrite, k == 0);
            chk("PCWrite", PCWrite, (k == 0) || (last && pcWLast));
            chk("RegWrite", RegWrite, last && regWLast);
            chk("MemWrite", MemWrite, last && memWLast);
            case (seq[k])
                0, 1, 9: aluExp = 4'b0100;
                2:       aluExp = ins[23] ? 4'b0100 : 4'b0010;
                6, 7:    aluExp = cmd;
                default: aluExp = 4'b0000;
            endcase
            chk("ALUControl", ALUControl, aluExp);
            case (seq[k])
                1:       rsExp = {1'b0, op == 2'b01 && !ins[20], op == 2'b10};
                5:       rsExp = 3'b010;
                9:       rsExp = {lnk, 1'b0, 1'b1};
                default: rsExp = 3'b000;
            endcase
            chk("RegSrc", RegSrc, rsExp);
            chk("muxSel", {ALUSrcA, AdrSrc, WDSrc, shifterSrc, shSrc, ALUSrcB, ImmSrc, shamtSrc, ResultSrc},
                expMux(seq[k], lnk));
            @(negedge clk);
        end
        if (condOk && op == 2'b00 && (ins[20] || isCmp)) zf = z;
    endtask

    initial begin
        reset = 1'b0;
        Instr = 32'h0;
        Z     = 1'b0;
        #1;
        chk("rst.state", state, 0);
        chk("rst.we", {RegWrite, MemWrite, PCWrite, IRWrite}, 4'b0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel.IRWrite", IRWrite, 1);

        // Directed instruction classes
        runInstr(32'hE2821005, 1'b0);   // ADD R1,R2,#5
        runInstr(32'hE5921004, 1'b0);   // LDR
        runInstr(32'hE5821004, 1'b0);   // STR
        runInstr(32'hE3510000, 1'b1);   // CMP R1,#0 with Z=1
        chk("zf.after.cmp", zf, 1);
        runInstr(32'h0A000002, 1'b0);   // BEQ taken
        runInstr(32'h1A000002, 1'b0);   // BNE untaken
        runInstr(32'hEB000004, 1'b0);   // BL
        runInstr(32'hE281F004, 1'b0);   // ADD PC,R1,#4
        runInstr(32'hE5121004, 1'b0);   // LDR with U=0 (SUB address)
        runInstr(32'hF0000000, 1'b0);   // cond 1111 never executes

        // Reset asserted mid-LDR during MEMREAD
        Instr = 32'hE5921004;
        #1;
        repeat (3) @(negedge clk);
        chk("pre.rst.state", state, 3);
        #2 reset = 1'b0;
        #1;
        chk("midrst.state", state, 0);
        chk("midrst.we", {RegWrite, MemWrite, PCWrite, IRWrite}, 4'b0000);
        @(negedge clk);
        chk("midrst.hold", state, 0);
        reset = 1'b1;
        zf = 1'b0;
        #1;
        chk("midrst.rel.state", state, 0);
        chk("midrst.rel.IRWrite", IRWrite, 1);
        runInstr(32'h0A000002, 1'b0);   // BEQ untaken: flag cleared by reset

        // Random instructions
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: ins[31:28] = 4'h0;
                1: ins[31:28] = 4'h1;
                2: ins[31:28] = 4'hE;
                default: ;
            endcase
            runInstr(ins, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
